dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter that lets NCH requesters share one
// single-port RAM. Grants are combinational in the request cycle, and read data
// returns through a tag pipeline that is RD_LAT stages deep. The block also keeps
// a saturating contention counter and a sticky flag for read+write collisions.
//
// Request/accept semantics: a channel holds ch_ren/ch_wren (with its address and
// data) until it sees ch_gnt in the same cycle, and the access is taken on that
// cycle's rising edge. ch_rvalid is a one-cycle strobe with no back-pressure.
module dmem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int NCH    = 2,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH-1:0]           ch_ren,
  input  logic [NCH-1:0]           ch_wren,
  input  logic [NCH*ADDR_W-1:0]    ch_addr,
  input  logic [NCH*DATA_W-1:0]    ch_wdata,
  output logic [NCH-1:0]           ch_gnt,
  output logic [NCH-1:0]           ch_rvalid,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_ren,
  output logic                     mem_wren,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [15:0]              conflict_cnt,
  output logic                     rw_err
);

  localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;

  // Round-robin pointer: the index of the highest-priority channel.
  logic [NCH-1:0]  ptr_q, ptr_d;
  // Read-return tags. Stage 0 is the first stage; stage RD_LAT-1 drives ch_rvalid.
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [IDW-1:0]    tag_id_q [RD_LAT];
  logic [IDW-1:0]    tag_id_d [RD_LAT];
  logic [15:0]     cnt_q, cnt_d;
  logic            rw_err_q, rw_err_d;

  logic [NCH-1:0]  req;
  logic [NCH-1:0]  req_rot;
  logic            gnt_vld;
  int unsigned     gnt_idx;
  int unsigned     sel;
  logic [3:0]      n_req;

  // Requests are gated by reset, so no grant or memory strobe appears while rst_n is low.
  assign req = (ch_ren | ch_wren) & {NCH{rst_n}};

  // Pick the first requester at or after the pointer, wrapping from NCH-1 to 0.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 0;
    sel     = 0;
    req_rot = '0;
    for (int k = 0; k < NCH; k++) begin
      sel     = (int'(ptr_q) + k) % NCH;
      req_rot = req >> sel;
      if (!gnt_vld && req_rot[0]) begin
        gnt_vld = 1'b1;
        gnt_idx = sel;
      end
    end
  end

  // Steer the granted channel onto the RAM port. Read+write collapses to a write.
  always_comb begin
    logic [NCH-1:0] ren_sh;
    logic [NCH-1:0] wren_sh;
    ch_gnt    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_ren   = 1'b0;
    mem_wren  = 1'b0;
    ren_sh    = ch_ren >> gnt_idx;
    wren_sh   = ch_wren >> gnt_idx;
    if (gnt_vld) begin
      ch_gnt    = NCH'(1) << gnt_idx;
      mem_addr  = ADDR_W'(ch_addr >> (gnt_idx * ADDR_W));
      mem_wdata = DATA_W'(ch_wdata >> (gnt_idx * DATA_W));
      mem_wren  = wren_sh[0];
      mem_ren   = ren_sh[0] & ~wren_sh[0];
    end
  end

  // Next state: pointer advance, tag shift, contention count, collision flag.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = NCH'((gnt_idx + 1) % NCH);

    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = mem_ren;
    tag_id_d[0]  = IDW'(gnt_idx);
    for (int s = 1; s < RD_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end

    n_req = '0;
    for (int i = 0; i < NCH; i++) n_req = n_req + {3'b000, req[i]};
    cnt_d = cnt_q;
    if ((n_req > 4'd1) && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;

    rw_err_d = rw_err_q | (|(ch_ren & ch_wren));
  end

  // State registers; reset also flushes every in-flight read tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      tag_vld_q <= '0;
      for (int s = 0; s < RD_LAT; s++) tag_id_q[s] <= '0;
      cnt_q     <= '0;
      rw_err_q  <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      tag_vld_q <= tag_vld_d;
      for (int s = 0; s < RD_LAT; s++) tag_id_q[s] <= tag_id_d[s];
      cnt_q     <= cnt_d;
      rw_err_q  <= rw_err_d;
    end
  end

  // Return strobe from the last tag stage; the shared data bus is zero when idle.
  always_comb begin
    ch_rvalid = '0;
    if (tag_vld_q[RD_LAT-1]) ch_rvalid = NCH'(1) << tag_id_q[RD_LAT-1];
    ch_rdata = (|ch_rvalid) ? mem_rdata : '0;
  end

  assign conflict_cnt = cnt_q;
  assign rw_err       = rw_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. Two instances run side by side: A (NCH=2, RD_LAT=1)
// and B (NCH=3, RD_LAT=2). Each one is backed by a behavioural RAM. A
// specification-level model is checked on every falling edge, and directed
// literal checks pin the model at the points of interest.
module tb_dmem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic [1:0]  ren_a, wren_a, gnt_a, rv_a;
  logic [21:0] addr_a;
  logic [31:0] wd_a;
  logic [15:0] rdata_a, mwd_a, mrd_a, cnt_a;
  logic [10:0] maddr_a;
  logic        mren_a, mwren_a, err_a;

  dmem_arbiter #(.DATA_W(16), .ADDR_W(11), .NCH(2), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .ch_ren(ren_a), .ch_wren(wren_a), .ch_addr(addr_a),
    .ch_wdata(wd_a), .ch_gnt(gnt_a), .ch_rvalid(rv_a), .ch_rdata(rdata_a),
    .mem_addr(maddr_a), .mem_wdata(mwd_a), .mem_ren(mren_a), .mem_wren(mwren_a),
    .mem_rdata(mrd_a), .conflict_cnt(cnt_a), .rw_err(err_a));

  // ---------------- instance B ----------------
  logic [2:0]  ren_b, wren_b, gnt_b, rv_b;
  logic [32:0] addr_b;
  logic [47:0] wd_b;
  logic [15:0] rdata_b, mwd_b, mrd_b, cnt_b;
  logic [10:0] maddr_b;
  logic        mren_b, mwren_b, err_b;

  dmem_arbiter #(.DATA_W(16), .ADDR_W(11), .NCH(3), .RD_LAT(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ch_ren(ren_b), .ch_wren(wren_b), .ch_addr(addr_b),
    .ch_wdata(wd_b), .ch_gnt(gnt_b), .ch_rvalid(rv_b), .ch_rdata(rdata_b),
    .mem_addr(maddr_b), .mem_wdata(mwd_b), .mem_ren(mren_b), .mem_wren(mwren_b),
    .mem_rdata(mrd_b), .conflict_cnt(cnt_b), .rw_err(err_b));

  // ---------------- behavioural RAMs ----------------
  logic [15:0] ram_a [2048];
  logic [15:0] ram_b [2048];
  logic [15:0] rp_a, rp_b0, rp_b1;
  assign mrd_a = rp_a;
  assign mrd_b = rp_b1;

  always @(posedge clk) begin
    if (mwren_a) ram_a[maddr_a] <= mwd_a;
    if (mren_a)  rp_a <= ram_a[maddr_a];
    if (mwren_b) ram_b[maddr_b] <= mwd_b;
    if (mren_b)  rp_b0 <= ram_b[maddr_b];
    rp_b1 <= rp_b0;
  end

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int          inst;
    int          due;
    int          ch;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  int          m_ptr [2];
  int          m_cnt [2];
  logic        m_err [2];
  logic [15:0] m_mem [2][2048];

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram_a[i] = '0; ram_b[i] = '0; m_mem[0][i] = '0; m_mem[1][i] = '0;
    end
    rp_a = '0; rp_b0 = '0; rp_b1 = '0;
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0; m_cnt[k] = 0; m_err[k] = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Spec model for one instance: compare outputs, then advance to the next edge.
  task automatic check_inst(input int k, input string p, input int nch, input int lat,
    input logic [7:0] ren, input logic [7:0] wren, input logic [87:0] addr,
    input logic [127:0] wd, input logic [7:0] gnt, input logic [7:0] rv,
    input logic [15:0] rdata, input logic [10:0] maddr, input logic [15:0] mwd,
    input logic mren, input logic mwren, input logic [15:0] cnt, input logic err);
    logic [7:0]  mask, req, e_gnt, e_rv;
    logic [15:0] e_rd, e_wd;
    logic [10:0] e_addr;
    logic        e_ren, e_wren;
    int          g, c, nreq;
    mask = 8'((9'd1 << nch) - 9'd1);
    e_gnt = '0; e_rv = '0; e_rd = '0; e_wd = '0; e_addr = '0; e_ren = 1'b0; e_wren = 1'b0;
    if (!rst_n) begin
      m_ptr[k] = 0; m_cnt[k] = 0; m_err[k] = 1'b0;
    end else begin
      req = (ren | wren) & mask;
      g = -1;
      for (int j = 0; j < nch; j++) begin
        c = (m_ptr[k] + j) % nch;
        if (g < 0 && req[c[2:0]]) g = c;
      end
      if (g >= 0) begin
        e_gnt  = 8'd1 << g;
        e_addr = 11'(addr >> (g * 11));
        e_wd   = 16'(wd >> (g * 16));
        e_wren = wren[g[2:0]];
        e_ren  = ren[g[2:0]] & ~wren[g[2:0]];
      end
      foreach (exp_q[i])
        if (exp_q[i].inst == k && exp_q[i].due == cyc) begin
          e_rv = 8'd1 << exp_q[i].ch;
          e_rd = exp_q[i].data;
        end
    end
    chk({p, "_gnt"},    32'(gnt),   32'(e_gnt));
    chk({p, "_rvalid"}, 32'(rv),    32'(e_rv));
    chk({p, "_rdata"},  32'(rdata), 32'(e_rd));
    chk({p, "_maddr"},  32'(maddr), 32'(e_addr));
    chk({p, "_mwdata"}, 32'(mwd),   32'(e_wd));
    chk({p, "_mren"},   32'(mren),  32'(e_ren));
    chk({p, "_mwren"},  32'(mwren), 32'(e_wren));
    chk({p, "_cnt"},    32'(cnt),   32'(m_cnt[k]));
    chk({p, "_rw_err"}, 32'(err),   32'(m_err[k]));
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].inst == k && (!rst_n || exp_q[i].due <= cyc)) exp_q.delete(i);
    if (rst_n) begin
      nreq = 0;
      for (int i = 0; i < nch; i++) nreq += int'(req[i]);
      if (nreq > 1 && m_cnt[k] < 65535) m_cnt[k]++;
      if (|(ren & wren & mask)) m_err[k] = 1'b1;
      if (g >= 0) begin
        m_ptr[k] = (g + 1) % nch;
        if (e_wren) m_mem[k][e_addr] = e_wd;
        else if (e_ren) exp_q.push_back('{k, cyc + lat, g, m_mem[k][e_addr]});
      end
    end
  endtask

  // Single compare process: every falling edge, both instances against the model.
  always @(negedge clk) begin
    cyc++;
    check_inst(0, "a", 2, 1, {6'b0, ren_a}, {6'b0, wren_a}, {66'b0, addr_a}, {96'b0, wd_a},
               {6'b0, gnt_a}, {6'b0, rv_a}, rdata_a, maddr_a, mwd_a, mren_a, mwren_a, cnt_a, err_a);
    check_inst(1, "b", 3, 2, {5'b0, ren_b}, {5'b0, wren_b}, {55'b0, addr_b}, {80'b0, wd_b},
               {5'b0, gnt_b}, {5'b0, rv_b}, rdata_b, maddr_b, mwd_b, mren_b, mwren_b, cnt_b, err_b);
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_a(input logic [1:0] r, input logic [1:0] w, input logic [10:0] a0,
                       input logic [10:0] a1, input logic [15:0] d0, input logic [15:0] d1);
    ren_a = r; wren_a = w; addr_a = {a1, a0}; wd_a = {d1, d0};
  endtask

  task automatic set_b(input logic [2:0] r, input logic [2:0] w, input logic [10:0] a0,
                       input logic [10:0] a1, input logic [10:0] a2, input logic [15:0] d0,
                       input logic [15:0] d1, input logic [15:0] d2);
    ren_b = r; wren_b = w; addr_b = {a2, a1, a0}; wd_b = {d2, d1, d0};
  endtask

  task automatic idle_all();
    set_a(2'b00, 2'b00, 11'd0, 11'd0, 16'd0, 16'd0);
    set_b(3'b000, 3'b000, 11'd0, 11'd0, 11'd0, 16'd0, 16'd0, 16'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle_all();
    // Requests are held during reset and must not be granted.
    set_a(2'b11, 2'b00, 11'd0, 11'd1, 16'd0, 16'd0);
    sample();
    chk("rst_gnt_a", 32'(gnt_a), 32'd0);
    chk("rst_mren_a", 32'(mren_a), 32'd0);
    chk("rst_cnt_a", 32'(cnt_a), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    idle_all();
    sample();

    // Two channels contending from reset: strict alternation starting at ch0.
    next_cycle(); set_a(2'b11, 2'b00, 11'd0, 11'd1, 16'd0, 16'd0); sample();
    chk("rr_gnt1", 32'(gnt_a), 32'h1);
    next_cycle(); sample(); chk("rr_gnt2", 32'(gnt_a), 32'h2);
    next_cycle(); sample(); chk("rr_gnt3", 32'(gnt_a), 32'h1);
    next_cycle(); sample(); chk("rr_gnt4", 32'(gnt_a), 32'h2);
    next_cycle(); idle_all(); sample();
    chk("rr_cnt", 32'(cnt_a), 32'd4);

    // Single requester: write then read back with one cycle of latency.
    next_cycle(); set_a(2'b00, 2'b01, 11'd5, 11'd0, 16'hBEEF, 16'd0); sample();
    chk("wr5_gnt", 32'(gnt_a), 32'h1);
    next_cycle(); set_a(2'b01, 2'b00, 11'd5, 11'd0, 16'd0, 16'd0); sample();
    chk("rd5_gnt", 32'(gnt_a), 32'h1);
    next_cycle(); idle_all(); sample();
    chk("rd5_rvalid", 32'(rv_a), 32'h1);
    chk("rd5_rdata", 32'(rdata_a), 32'hBEEF);

    // Read and write together: write only, no return, sticky error.
    next_cycle(); set_a(2'b01, 2'b01, 11'd9, 11'd0, 16'h1234, 16'd0); sample();
    chk("rw_gnt", 32'(gnt_a), 32'h1);
    chk("rw_mwren", 32'(mwren_a), 32'h1);
    chk("rw_mren", 32'(mren_a), 32'h0);
    next_cycle(); idle_all(); sample();
    chk("rw_no_rvalid", 32'(rv_a), 32'h0);
    chk("rw_err_set", 32'(err_a), 32'h1);
    next_cycle(); set_a(2'b01, 2'b00, 11'd9, 11'd0, 16'd0, 16'd0); sample();
    next_cycle(); idle_all(); sample();
    chk("rd9_rdata", 32'(rdata_a), 32'h1234);
    chk("rw_err_sticky", 32'(err_a), 32'h1);

    // Instance B, RD_LAT=2: back-to-back reads return in grant order.
    next_cycle(); set_b(3'b000, 3'b100, 11'd0, 11'd0, 11'd3, 16'd0, 16'd0, 16'h3333); sample();
    chk("b_wr3_gnt", 32'(gnt_b), 32'h4);
    next_cycle(); set_b(3'b000, 3'b100, 11'd0, 11'd0, 11'd7, 16'd0, 16'd0, 16'h7777); sample();
    next_cycle(); set_b(3'b010, 3'b000, 11'd0, 11'd3, 11'd0, 16'd0, 16'd0, 16'd0); sample();
    chk("b_rd1_gnt", 32'(gnt_b), 32'h2);
    next_cycle(); set_b(3'b001, 3'b000, 11'd7, 11'd0, 11'd0, 16'd0, 16'd0, 16'd0); sample();
    chk("b_rd0_gnt", 32'(gnt_b), 32'h1);
    chk("b_t1_rvalid", 32'(rv_b), 32'h0);
    next_cycle(); idle_all(); sample();
    chk("b_t2_rvalid", 32'(rv_b), 32'h2);
    chk("b_t2_rdata", 32'(rdata_b), 32'h3333);
    next_cycle(); sample();
    chk("b_t3_rvalid", 32'(rv_b), 32'h1);
    chk("b_t3_rdata", 32'(rdata_b), 32'h7777);

    // Read granted, then reset before its return cycle: the return is dropped.
    next_cycle(); set_a(2'b01, 2'b00, 11'd5, 11'd0, 16'd0, 16'd0); sample();
    chk("rst_rd_gnt", 32'(gnt_a), 32'h1);
    #3;
    rst_n = 1'b0;
    idle_all();
    next_cycle(); sample();
    chk("rst_rd_rvalid", 32'(rv_a), 32'h0);
    next_cycle(); rst_n = 1'b1; sample();
    chk("post_rst_rvalid", 32'(rv_a), 32'h0);
    chk("post_rst_cnt", 32'(cnt_a), 32'h0);
    chk("post_rst_err", 32'(err_a), 32'h0);
    next_cycle(); set_a(2'b11, 2'b00, 11'd2, 11'd3, 16'd0, 16'd0); sample();
    chk("post_rst_gnt", 32'(gnt_a), 32'h1);

    // Saturation: 65534 contention cycles reach FFFE, then more cycles stick at FFFF.
    repeat (65533) next_cycle();
    next_cycle(); idle_all(); sample();
    chk("sat_fffe", 32'(cnt_a), 32'hFFFE);
    next_cycle(); set_a(2'b11, 2'b00, 11'd2, 11'd3, 16'd0, 16'd0);
    repeat (2) next_cycle();
    next_cycle(); idle_all(); sample();
    chk("sat_ffff", 32'(cnt_a), 32'hFFFF);
    next_cycle(); set_a(2'b11, 2'b00, 11'd2, 11'd3, 16'd0, 16'd0);
    next_cycle();
    next_cycle(); idle_all(); sample();
    chk("sat_hold", 32'(cnt_a), 32'hFFFF);

    // Random mix on both instances; the model does the checking.
    for (int n = 0; n < 300; n++) begin
      next_cycle();
      set_a(2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3) & $urandom_range(0, 3) & $urandom_range(0, 3)),
            11'($urandom_range(0, 15)), 11'($urandom_range(0, 15)),
            16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      set_b(3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7) & $urandom_range(0, 7) & $urandom_range(0, 7)),
            11'($urandom_range(0, 15)), 11'($urandom_range(0, 15)), 11'($urandom_range(0, 15)),
            16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
            16'($urandom_range(0, 65535)));
    end
    next_cycle(); idle_all();
    repeat (4) next_cycle();
    sample();

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
